// File: rtl/topo_control.sv
// topo_control: 3x3 whack-a-mole game controller.
// Places moles, drives cursor and strike pulse, keeps score and misses.
module topo_control #(
    parameter int unsigned TICKS_PER_MOLE = 25000000,
    parameter int unsigned MAX_MISSES     = 5,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_LEFT,
    input  logic       BTN_RIGHT,
    input  logic       BTN_HIT,
    input  logic [8:0] HIT,
    output logic [8:0] PONER_TOPO,
    output logic [8:0] SELECT,
    output logic       GOLPE,
    output logic [7:0] SCORE,
    output logic [3:0] MISSES,
    output logic       GAME_OVER
);

    localparam int TW = (TICKS_PER_MOLE > 1) ? $clog2(TICKS_PER_MOLE) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TICKS_PER_MOLE - 1);
    localparam logic [3:0] MISS_LIM = 4'(MAX_MISSES);

    typedef enum logic [1:0] {
        IDLE,
        SPAWN,
        ACTIVE,
        GAMEOVER
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    btn_q;
    logic [1:0]    row_q, row_d;
    logic [1:0]    col_q, col_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    misses_q, misses_d;
    logic          golpe_q, golpe_d;
    logic          up_e, dn_e, lf_e, rt_e, hit_e;
    logic [3:0]    raw, pick;
    logic [3:0]    cur_pos;

    assign up_e  = BTN_UP    & ~btn_q[0];
    assign dn_e  = BTN_DOWN  & ~btn_q[1];
    assign lf_e  = BTN_LEFT  & ~btn_q[2];
    assign rt_e  = BTN_RIGHT & ~btn_q[3];
    assign hit_e = BTN_HIT   & ~btn_q[4];

    assign lfsr_d = {lfsr_q[6:0],
                     lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign cur_pos = {1'b0, row_q, 1'b0} + {2'b00, row_q} + {2'b00, col_q};

    assign SELECT     = 9'b1 << cur_pos;
    assign PONER_TOPO = (state_q == ACTIVE) ? (9'b1 << idx_q) : 9'b0;
    assign GOLPE      = golpe_q;
    assign SCORE      = score_q;
    assign MISSES     = misses_q;
    assign GAME_OVER  = (state_q == GAMEOVER);

    // Cell choice: fold LFSR nibble into 0..8, never repeat the last cell.
    always_comb begin
        raw = lfsr_q[3:0];
        if (raw > 4'd8) raw = raw - 4'd9;
        pick = raw;
        if (raw == idx_q) pick = (raw == 4'd8) ? 4'd0 : raw + 4'd1;
    end

    // Saturating cursor move; opposite edges in one cycle cancel.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (up_e && !dn_e && row_q != 2'd0) row_d = row_q - 2'd1;
        else if (dn_e && !up_e && row_q != 2'd2) row_d = row_q + 2'd1;
        if (lf_e && !rt_e && col_q != 2'd0) col_d = col_q - 2'd1;
        else if (rt_e && !lf_e && col_q != 2'd2) col_d = col_q + 2'd1;
    end

    // Game FSM next-state, score/miss bookkeeping and strike pulse.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        score_d  = score_q;
        misses_d = misses_q;
        unique case (state_q)
            IDLE: begin
                if (hit_e) state_d = SPAWN;
            end
            SPAWN: begin
                idx_d   = pick;
                timer_d = '0;
                state_d = ACTIVE;
            end
            ACTIVE: begin
                timer_d = timer_q + TW'(1);
                if (HIT[idx_q]) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    state_d = SPAWN;
                end else if (timer_q == TMAX) begin
                    misses_d = misses_q + 4'd1;
                    state_d  = (misses_d == MISS_LIM) ? GAMEOVER : SPAWN;
                end
            end
            GAMEOVER: begin
                if (hit_e) begin
                    score_d  = 8'd0;
                    misses_d = 4'd0;
                    state_d  = SPAWN;
                end
            end
        endcase
        golpe_d = hit_e && (state_q == ACTIVE) && (state_d == ACTIVE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            btn_q    <= '0;
            row_q    <= 2'd1;
            col_q    <= 2'd1;
            lfsr_q   <= LFSR_SEED;
            timer_q  <= '0;
            idx_q    <= 4'd4;
            score_q  <= 8'd0;
            misses_q <= 4'd0;
            golpe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            btn_q    <= {BTN_HIT, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};
            row_q    <= row_d;
            col_q    <= col_d;
            lfsr_q   <= lfsr_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            golpe_q  <= golpe_d;
        end
    end

endmodule

// File: tb/tb_topo_control.sv
// tb_topo_control: directed checks of topo_control with short mole timeout.
// Tracks the LFSR and cursor independently to predict moles and SELECT.
module tb_topo_control;

    logic       Clock = 1'b0;
    logic       reset;
    logic       BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_HIT;
    logic [8:0] HIT;
    logic [8:0] PONER_TOPO, SELECT;
    logic       GOLPE, GAME_OVER;
    logic [7:0] SCORE;
    logic [3:0] MISSES;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_lfsr;
    logic [3:0] prev;
    logic [3:0] old;
    logic [3:0] e;
    int cur_r, cur_c;
    int up_cnt;
    int bad;

    topo_control #(
        .TICKS_PER_MOLE(8),
        .MAX_MISSES(3),
        .LFSR_SEED(8'hA5)
    ) dut (
        .Clock(Clock),
        .reset(reset),
        .BTN_UP(BTN_UP),
        .BTN_DOWN(BTN_DOWN),
        .BTN_LEFT(BTN_LEFT),
        .BTN_RIGHT(BTN_RIGHT),
        .BTN_HIT(BTN_HIT),
        .HIT(HIT),
        .PONER_TOPO(PONER_TOPO),
        .SELECT(SELECT),
        .GOLPE(GOLPE),
        .SCORE(SCORE),
        .MISSES(MISSES),
        .GAME_OVER(GAME_OVER)
    );

    always #5 Clock = ~Clock;

    // Reference LFSR stepping with the same clock and reset.
    always @(posedge Clock or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else m_lfsr <= {m_lfsr[6:0],
                        m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [3:0] cell_pick(input logic [7:0] l,
                                             input logic [3:0] p);
        logic [3:0] c;
        c = l[3:0];
        if (c > 4'd8) c = c - 4'd9;
        if (c == p) c = (c == 4'd8) ? 4'd0 : c + 4'd1;
        return c;
    endfunction

    function automatic logic [8:0] oh(input logic [3:0] i);
        return 9'b1 << i;
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic l,
                         input logic r, input logic h);
        BTN_UP = u; BTN_DOWN = d; BTN_LEFT = l; BTN_RIGHT = r; BTN_HIT = h;
        tick;
        BTN_UP = 0; BTN_DOWN = 0; BTN_LEFT = 0; BTN_RIGHT = 0; BTN_HIT = 0;
        tick;
    endtask

    // Called just after the edge that entered SPAWN.
    task automatic do_spawn(input string tag);
        logic [3:0] ex;
        ex = cell_pick(m_lfsr, prev);
        chk({tag, "_spawn_empty"}, 32'(PONER_TOPO), 32'h0);
        tick;
        chk({tag, "_mole"}, 32'(PONER_TOPO), 32'(oh(ex)));
        prev = ex;
    endtask

    task automatic steer(input logic [3:0] idx);
        int tr, tc;
        logic u, d, l, r;
        tr = int'(idx) / 3;
        tc = int'(idx) % 3;
        repeat (2) begin
            u = (tr < cur_r); d = (tr > cur_r);
            l = (tc < cur_c); r = (tc > cur_c);
            if (u | d | l | r) begin
                press(u, d, l, r, 1'b0);
                cur_r = cur_r + int'(d) - int'(u);
                cur_c = cur_c + int'(r) - int'(l);
            end
        end
    endtask

    initial begin
        reset = 0;
        BTN_UP = 0; BTN_DOWN = 0; BTN_LEFT = 0; BTN_RIGHT = 0; BTN_HIT = 0;
        HIT = '0;
        prev = 4'd4;
        cur_r = 1; cur_c = 1;
        repeat (3) tick;
        chk("rst_select", 32'(SELECT), 32'h010);
        chk("rst_poner", 32'(PONER_TOPO), 32'h0);
        chk("rst_golpe", 32'(GOLPE), 32'h0);
        chk("rst_score", 32'(SCORE), 32'h0);
        chk("rst_misses", 32'(MISSES), 32'h0);
        chk("rst_gameover", 32'(GAME_OVER), 32'h0);

        reset = 1;
        repeat (20) tick;
        chk("idle_select", 32'(SELECT), 32'h010);
        chk("idle_poner", 32'(PONER_TOPO), 32'h0);
        chk("idle_score", 32'(SCORE), 32'h0);
        chk("idle_gameover", 32'(GAME_OVER), 32'h0);

        repeat (3) press(1, 0, 0, 0, 0);
        chk("cur_top", 32'(SELECT), 32'h002);
        repeat (3) press(0, 0, 1, 0, 0);
        chk("cur_topleft", 32'(SELECT), 32'h001);
        repeat (3) press(0, 1, 0, 0, 0);
        chk("cur_bottom", 32'(SELECT), 32'h040);
        repeat (3) press(0, 0, 0, 1, 0);
        chk("cur_botright", 32'(SELECT), 32'h100);
        BTN_LEFT = 1;
        repeat (50) tick;
        BTN_LEFT = 0;
        tick;
        chk("cur_hold_once", 32'(SELECT), 32'h080);
        press(1, 1, 0, 0, 0);
        chk("cur_updown_cancel", 32'(SELECT), 32'h080);
        press(1, 0, 1, 0, 0);
        chk("cur_diag", 32'(SELECT), 32'h008);
        cur_r = 1; cur_c = 0;

        BTN_HIT = 1;
        tick;
        BTN_HIT = 0;
        chk("idle_no_golpe", 32'(GOLPE), 32'h0);
        do_spawn("start");
        steer(prev);
        chk("steer_select", 32'(SELECT), 32'(oh(prev)));
        BTN_HIT = 1;
        tick;
        BTN_HIT = 0;
        chk("golpe_high", 32'(GOLPE), 32'h1);
        HIT = oh(prev);
        old = prev;
        tick;
        HIT = '0;
        chk("hit_score1", 32'(SCORE), 32'h1);
        chk("golpe_one_cycle", 32'(GOLPE), 32'h0);
        do_spawn("rehit");
        chk("new_cell_differs", 32'(PONER_TOPO != oh(old)), 32'h1);

        for (int i = 1; i <= 7; i++) begin
            HIT = (i == 3) ? (~oh(prev) & 9'h1FF) : 9'h0;
            tick;
        end
        chk("wrong_hit_ignored", 32'(SCORE), 32'h1);
        HIT = oh(prev);
        tick;
        HIT = '0;
        chk("collide_score", 32'(SCORE), 32'h2);
        chk("collide_misses", 32'(MISSES), 32'h0);
        do_spawn("collide");

        for (int n = 1; n <= 3; n++) begin
            up_cnt = 1;
            for (int i = 1; i <= 7; i++) begin
                tick;
                if (PONER_TOPO === oh(prev)) up_cnt++;
            end
            chk("mole_up_8", 32'(up_cnt), 32'd8);
            if (n == 1) BTN_HIT = 1;
            tick;
            BTN_HIT = 0;
            chk("timeout_poner", 32'(PONER_TOPO), 32'h0);
            chk("timeout_misses", 32'(MISSES), 32'(n));
            if (n == 1) chk("lost_strike", 32'(GOLPE), 32'h0);
            if (n < 3) do_spawn("timeout");
        end
        chk("go_flag", 32'(GAME_OVER), 32'h1);
        chk("go_score_held", 32'(SCORE), 32'h2);
        repeat (5) tick;
        chk("go_stays", 32'(GAME_OVER), 32'h1);
        chk("go_no_mole", 32'(PONER_TOPO), 32'h0);

        BTN_HIT = 1;
        tick;
        BTN_HIT = 0;
        chk("restart_score", 32'(SCORE), 32'h0);
        chk("restart_misses", 32'(MISSES), 32'h0);
        chk("restart_go", 32'(GAME_OVER), 32'h0);
        do_spawn("restart");

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            HIT = oh(prev);
            tick;
            HIT = '0;
            if (i == 253) chk("score_254", 32'(SCORE), 32'd254);
            if (i == 254) chk("score_255", 32'(SCORE), 32'd255);
            e = cell_pick(m_lfsr, prev);
            tick;
            if (PONER_TOPO !== oh(e)) bad++;
            prev = e;
        end
        chk("sat_moles", 32'(bad), 32'd0);
        chk("score_saturated", 32'(SCORE), 32'd255);

        tick;
        chk("pre_reset_mole", 32'(PONER_TOPO), 32'(oh(prev)));
        #2;
        reset = 0;
        #1;
        chk("async_poner", 32'(PONER_TOPO), 32'h0);
        chk("async_score", 32'(SCORE), 32'h0);
        chk("async_select", 32'(SELECT), 32'h010);
        chk("async_misses", 32'(MISSES), 32'h0);
        chk("async_golpe", 32'(GOLPE), 32'h0);
        tick;
        reset = 1;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/topo_control.md
Name: topo_control

Overview:
- Game controller for the 3x3 whack-a-mole VGA board; sits directly upstream of the nine mole cells.
- Places one mole at a time via PONER_TOPO, with a pseudo-random cell choice and a per-mole timeout.
- Drives the one-hot cursor SELECT and the one-cycle GOLPE strike pulse from debounced buttons.
- Consumes the cells' HIT vector to keep score and miss count, and ends the game after too many misses.

Parameters:
- TICKS_PER_MOLE, 25000000: clock cycles a mole stays up before counting as a miss (1 s at 25 MHz).
- MAX_MISSES, 5: miss count that forces GAME_OVER (range 1..15).
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- BTN_UP  in  1  debounced level, cursor row-1.
- BTN_DOWN  in  1  debounced level, cursor row+1.
- BTN_LEFT  in  1  debounced level, cursor col-1.
- BTN_RIGHT  in  1  debounced level, cursor col+1.
- BTN_HIT  in  1  debounced level, strike / start.
- HIT  in  9  per-cell hit flags from the cells; bit i = cell i (i = row*3+col).
- PONER_TOPO  out  9  one-hot mole placement; all zero when no mole is up.
- SELECT  out  9  one-hot cursor position.
- GOLPE  out  1  strike pulse, one cycle wide.
- SCORE  out  8  hits so far; saturates at 255.
- MISSES  out  4  timed-out moles.
- GAME_OVER  out  1  high in GAMEOVER state.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state=IDLE; cursor row=1, col=1, so SELECT=9'b000010000.
  - PONER_TOPO=0, GOLPE=0, SCORE=0, MISSES=0, GAME_OVER=0.
  - LFSR=LFSR_SEED; timer=0; prev_idx=4; all button edge registers=0.
- Edge detect: each button has a registered previous level; an action fires on the cycle where the level is 1 and the previous level is 0. Holding a button gives exactly one action.
- Cursor:
  - Moves in every state.
  - Saturates at the edges (no wrap): UP at row 0 and LEFT at col 0 do nothing; DOWN at row 2 and RIGHT at col 2 do nothing.
  - Simultaneous edges: the vertical and horizontal moves both apply; UP+DOWN together cancel; LEFT+RIGHT together cancel.
  - SELECT is registered and updates the cycle after the edge.
- LFSR:
  - 8-bit, free-running every cycle in all states.
  - Each cycle: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Cell choice (SPAWN state):
  - c = lfsr[3:0]; if c > 8 then c = c - 9.
  - If c == prev_idx then c = (c == 8) ? 0 : c + 1.
  - Register idx = c and prev_idx = c.
- GOLPE: registered output, high for exactly one cycle following a BTN_HIT edge, and only while state=ACTIVE. Because the cells form HIT combinationally, HIT arrives in the same cycle GOLPE is high.
- State machine:
  - IDLE: PONER_TOPO=0. A BTN_HIT edge moves to SPAWN; it does not generate GOLPE.
  - SPAWN (one cycle): choose idx; PONER_TOPO=0 during this cycle; timer=0; next state ACTIVE.
  - ACTIVE: PONER_TOPO=one-hot(idx); timer increments each cycle. Exit conditions, in priority order:
    - HIT[idx]=1: SCORE+1 (saturating), next state SPAWN.
    - Otherwise timer == TICKS_PER_MOLE-1: MISSES+1. If the new value equals MAX_MISSES, next state GAMEOVER; else SPAWN.
    - HIT on any bit other than idx is ignored. A strike on an empty cell carries no penalty.
  - GAMEOVER: PONER_TOPO=0, GAME_OVER=1, SCORE and MISSES held. A BTN_HIT edge clears SCORE, MISSES and GAME_OVER and moves to SPAWN.
- Simultaneous events:
  - A hit in the timeout cycle counts as a hit; MISSES is unchanged.
  - A BTN_HIT edge in the same cycle as the timeout produces GOLPE in the next cycle, when state is SPAWN, so GOLPE stays 0; that strike is lost.
- Reset mid-game: the asynchronous clear applies immediately regardless of state; PONER_TOPO drops to 0 without waiting for a clock edge.

Test Plan:
- Reset/idle: assert reset=0, release, then run 20 cycles with no buttons -> SELECT=9'h010, PONER_TOPO=0, SCORE=0, GAME_OVER=0, and the LFSR has advanced from 8'hA5.
- Cursor saturation: from reset, 3 UP edges then 3 LEFT edges -> SELECT=9'h001. Then 3 DOWN and 3 RIGHT -> SELECT=9'h100. Holding RIGHT for 50 cycles moves it at most once.
- Hit scoring (TICKS_PER_MOLE=8):
  - Start the game; read idx from PONER_TOPO and steer the cursor there.
  - Pulse BTN_HIT and drive HIT[idx]=1 while GOLPE=1 -> SCORE=1 the next cycle, state SPAWN, and the new mole lands on a different cell.
- Timeout to game over (TICKS_PER_MOLE=8, MAX_MISSES=3):
  - With no strikes, each mole stays up exactly 8 cycles.
  - MISSES steps 1, 2, 3; GAME_OVER=1 after the 3rd timeout; PONER_TOPO=0.
  - A BTN_HIT edge then gives SCORE=0, MISSES=0 and a new spawn.
- Hit/timeout collision: drive HIT[idx]=1 in the cycle where timer=7 -> SCORE increments and MISSES is unchanged.
- Saturation and mid-game reset:
  - Force 256 hits -> SCORE stays 255.
  - Pull reset low mid-ACTIVE -> all outputs clear immediately, asynchronously.
